// File: rtl/msk_ct_out_buffer.sv
// Masked ciphertext output buffer.
// Collects 128-bit masked ciphertexts (d shares per bit) from the masked core
// and hands them downstream as four 32-bit masked words. Share groups are
// never recombined: storage, word selection and output all move whole
// d-share groups. A reservation counter tracks launched encryptions so the
// core only starts work whose result is guaranteed a slot.
//
// Handshake: a word moves downstream in every cycle where out_valid and
// out_ready are both high. out_valid never waits on out_ready, and out_data
// and out_last stay stable while out_valid is high and out_ready is low.
module msk_ct_out_buffer #(
  parameter int d     = 2,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              launch,
  output logic              credit_ok,
  input  logic              in_valid,
  input  logic [128*d-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*d-1:0]   out_data,
  output logic              out_last,
  output logic              err
);

  localparam int EW = 128 * d;
  localparam int WW = 32 * d;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] res;
  logic [1:0]    widx;
  logic          err_q;

  logic [CW:0]   occ;
  logic          full;
  logic          res_zero;
  logic          hs;
  logic          pop;
  logic          cap;
  logic          ovf;
  logic          launch_ok;
  logic          res_dec;
  logic          err_set;
  logic [EW-1:0] cur;
  logic [WW-1:0] word;

  // Ring pointer advance modulo DEPTH.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit counts both stored entries and encryptions still in flight.
  assign occ       = {1'b0, cnt} + {1'b0, res};
  assign credit_ok = (occ < DEPTH_W);

  assign full      = ({1'b0, cnt} == DEPTH_W);
  assign res_zero  = (res == '0);
  assign out_valid = (cnt != '0);
  assign hs        = out_valid & out_ready;
  // Final word of the head entry leaves: that entry's slot is freed.
  assign pop       = hs & (widx == 2'd3);
  // A full buffer still accepts a ciphertext when its head leaves this cycle.
  assign cap       = in_valid & (~full | pop);
  assign ovf       = in_valid & full & ~pop;

  assign launch_ok = launch & credit_ok;
  assign res_dec   = in_valid & ~res_zero;

  // Protocol violations: launch without credit, unreserved ciphertext, overflow.
  assign err_set   = (launch & ~credit_ok) | (in_valid & res_zero) | ovf;

  assign cur       = mem[rp];

  // Word selection on whole share groups of the head entry.
  always_comb begin
    word = '0;
    case (widx)
      2'd0: word = cur[0*WW +: WW];
      2'd1: word = cur[1*WW +: WW];
      2'd2: word = cur[2*WW +: WW];
      2'd3: word = cur[3*WW +: WW];
      default: word = '0;
    endcase
  end

  // Empty buffer drives the all-zero sharing rather than stale data.
  assign out_data = out_valid ? word : '0;
  assign out_last = out_valid & (widx == 2'd3);
  assign err      = err_q;

  // Ring pointers, occupancy and word index.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      widx <= '0;
    end else begin
      if (cap) wp <= next_ptr(wp);
      if (pop) rp <= next_ptr(rp);
      if (hs)  widx <= widx + 2'd1;
      case ({cap, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Reservation counter: launches in flight whose ciphertext is still due.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      res <= '0;
    end else begin
      case ({launch_ok, res_dec})
        2'b10:   res <= res + CW'(1);
        2'b01:   res <= res - CW'(1);
        default: res <= res;
      endcase
    end
  end

  // Entry storage: departing entries are wiped to zero; a coincident capture
  // into the same slot (full ring, wp == rp) is written last and wins.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) mem[rp] <= '0;
      if (cap) mem[wp] <= in_data;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

endmodule
